// File: rtl/bloom_filter_pkg.sv
// Shared types and default sizing for the bloom filter datapath.
// The window type and fill width are reused by the hash/LUT stage.
package bloom_filter_pkg;

  localparam int BYTE_W       = 8;
  localparam int MIN_STR_SIZE = 3;
  localparam int MAX_STR_SIZE = 20;
  localparam int FILL_W       = $clog2(MAX_STR_SIZE + 1);

  typedef logic [MAX_STR_SIZE-1:0][BYTE_W-1:0] str_window_t;

endpackage

// File: rtl/bloom_str_window_if.sv
// Avalon-ST byte sink plus windowed-beat source of the sliding-window stage.
// The slave modport is the window block's view; master is the neighbours' view.
interface bloom_str_window_if #(
  parameter int BYTE_W       = bloom_filter_pkg::BYTE_W,
  parameter int MAX_STR_SIZE = bloom_filter_pkg::MAX_STR_SIZE
);

  logic [BYTE_W-1:0]              snk_data_i;
  logic                           snk_valid_i;
  logic                           snk_startofpacket_i;
  logic                           snk_endofpacket_i;
  logic                           snk_ready_o;
  logic [MAX_STR_SIZE*BYTE_W-1:0] src_data_o;
  logic [MAX_STR_SIZE-1:0]        src_len_mask_o;
  logic                           src_endofpacket_o;
  logic                           src_valid_o;
  logic                           src_ready_i;

  modport slave (
    input  snk_data_i, snk_valid_i, snk_startofpacket_i, snk_endofpacket_i,
    input  src_ready_i,
    output snk_ready_o,
    output src_data_o, src_len_mask_o, src_endofpacket_o, src_valid_o
  );

  modport master (
    output snk_data_i, snk_valid_i, snk_startofpacket_i, snk_endofpacket_i,
    output src_ready_i,
    input  snk_ready_o,
    input  src_data_o, src_len_mask_o, src_endofpacket_o, src_valid_o
  );

endinterface

// File: rtl/bloom_str_window.sv
// Keeps the last MAX_STR_SIZE bytes of the current packet and emits one
// registered beat per accepted byte with a mask of in-packet substring lengths.
module bloom_str_window #(
  parameter int BYTE_W       = bloom_filter_pkg::BYTE_W,
  parameter int MIN_STR_SIZE = bloom_filter_pkg::MIN_STR_SIZE,
  parameter int MAX_STR_SIZE = bloom_filter_pkg::MAX_STR_SIZE
) (
  input logic               clk_i,
  input logic               rst_i,
  bloom_str_window_if.slave bus
);

  localparam int FILL_W = $clog2(MAX_STR_SIZE + 1);

  logic [MAX_STR_SIZE-1:0][BYTE_W-1:0] window;
  logic [MAX_STR_SIZE-1:0][BYTE_W-1:0] window_nxt;
  logic [FILL_W-1:0]                   fill;
  logic [FILL_W-1:0]                   fill_nxt;
  logic [MAX_STR_SIZE-1:0]             mask_nxt;
  logic                                in_pkt;
  logic                                accept;
  logic                                pkt_start;

  // Output slot is free when empty or being drained this cycle.
  assign bus.snk_ready_o = !bus.src_valid_o || bus.src_ready_i;
  assign accept          = bus.snk_valid_i && bus.snk_ready_o;
  assign pkt_start       = bus.snk_startofpacket_i || !in_pkt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    window_nxt    = '0;
    window_nxt[0] = bus.snk_data_i;
    for (int k = 1; k < MAX_STR_SIZE; k++) begin
      if (!pkt_start) window_nxt[k] = window[k-1];
    end

    if (pkt_start)                          fill_nxt = FILL_W'(1);
    else if (fill == FILL_W'(MAX_STR_SIZE)) fill_nxt = fill;
    else                                    fill_nxt = fill + FILL_W'(1);

    mask_nxt = '0;
    for (int k = 0; k < MAX_STR_SIZE; k++) begin
      mask_nxt[k] = (FILL_W'(k) < fill_nxt) && (k + 1 >= MIN_STR_SIZE);
    end
  end

  // The window register doubles as the output data register: both load only on accept.
  assign bus.src_data_o = window;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the window is reset because its zero-filled slots are visible downstream.
      window                <= '0;
      fill                  <= '0;
      in_pkt                <= 1'b0;
      bus.src_len_mask_o    <= '0;
      bus.src_endofpacket_o <= 1'b0;
      bus.src_valid_o       <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      window                <= window_nxt;
      fill                  <= fill_nxt;
      in_pkt                <= !bus.snk_endofpacket_i;
      bus.src_len_mask_o    <= mask_nxt;
      bus.src_endofpacket_o <= bus.snk_endofpacket_i;
      bus.src_valid_o       <= 1'b1;
    end else if (bus.src_ready_i) begin
      bus.src_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bloom_str_window.sv
// Directed and randomized checks of bloom_str_window against a packet-history
// scoreboard plus hand-computed windows and masks.
module tb_bloom_str_window;
  import bloom_filter_pkg::*;

  localparam int DW = MAX_STR_SIZE * BYTE_W;

  typedef struct packed {
    logic [DW-1:0]           data;
    logic [MAX_STR_SIZE-1:0] mask;
    logic                    eop;
  } beat_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  bloom_str_window_if #(.BYTE_W(BYTE_W), .MAX_STR_SIZE(MAX_STR_SIZE)) bus ();

  bloom_str_window #(
    .BYTE_W(BYTE_W), .MIN_STR_SIZE(MIN_STR_SIZE), .MAX_STR_SIZE(MAX_STR_SIZE)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  int   n_vec = 0;
  int   n_err = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  logic [BYTE_W-1:0] hist[$];
  bit   m_in_pkt = 1'b0;

  logic [MAX_STR_SIZE-1:0] abc_mask [5] = '{20'h0, 20'h0, 20'h4, 20'hC, 20'h1C};
  logic [MAX_STR_SIZE-1:0] bp_mask  [8] = '{20'h0, 20'h0, 20'h4, 20'hC, 20'h1C,
                                            20'h3C, 20'h7C, 20'hFC};

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected beat rebuilt from the bytes seen so far in the current packet.
  task automatic model_push(input logic [BYTE_W-1:0] d, input logic sop, input logic eop);
    beat_t b;
    if (sop || !m_in_pkt) hist.delete();
    hist.push_back(d);
    if (hist.size() > MAX_STR_SIZE) void'(hist.pop_front());
    m_in_pkt = !eop;
    b = '0;
    for (int k = 0; k < hist.size(); k++) begin
      b.data[k*BYTE_W +: BYTE_W] = hist[hist.size()-1-k];
      if (k + 1 >= MIN_STR_SIZE) b.mask[k] = 1'b1;
    end
    b.eop = eop;
    exp_q.push_back(b);
  endtask

  // One clock: drive inputs, score any beat leaving and any byte entering, advance.
  task automatic cycle(input logic v, input logic [BYTE_W-1:0] d, input logic sop,
                       input logic eop, input logic r, output bit accepted);
    beat_t b;
    beat_t e;
    bus.snk_valid_i         = v;
    bus.snk_data_i          = d;
    bus.snk_startofpacket_i = sop;
    bus.snk_endofpacket_i   = eop;
    bus.src_ready_i         = r;
    #1;
    if (bus.src_valid_o && bus.src_ready_i) begin
      b.data = bus.src_data_o;
      b.mask = bus.src_len_mask_o;
      b.eop  = bus.src_endofpacket_o;
      got_q.push_back(b);
      if (exp_q.size() == 0) begin
        check("sb_extra_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", b.data, e.data);
        check("sb_mask", b.mask, e.mask);
        check("sb_eop", b.eop, e.eop);
      end
    end
    accepted = v && bus.snk_ready_o;
    if (accepted) model_push(d, sop, eop);
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [BYTE_W-1:0] d, input logic sop, input logic eop,
                           input bit rnd);
    bit a;
    int tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 200) begin
      cycle(rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1, d, sop, eop,
            rnd ? 1'($urandom_range(0, 2) != 0) : 1'b1, a);
      tries++;
    end
    if (!a) check("accept_timeout", 0, 1);
  endtask

  task automatic drain(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    logic [DW-1:0]           held_data;
    logic [MAX_STR_SIZE-1:0] held_mask;
    int                      sent;
    int                      len;

    bus.snk_valid_i         = 1'b0;
    bus.snk_data_i          = '0;
    bus.snk_startofpacket_i = 1'b0;
    bus.snk_endofpacket_i   = 1'b0;
    bus.src_ready_i         = 1'b0;

    // Reset state
    #2;
    check("rst_valid", bus.src_valid_o, 0);
    check("rst_data", bus.src_data_o, 0);
    check("rst_mask", bus.src_len_mask_o, 0);
    check("rst_eop", bus.src_endofpacket_o, 0);
    check("rst_snk_ready", bus.snk_ready_o, 1);
    #15 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // "abcde"
    got_q.delete();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h61 + i), i == 0, i == 4, 1'b0);
    drain(2);
    check("abc_beats", got_q.size(), 5);
    if (got_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("abc_mask", got_q[i].mask, abc_mask[i]);
        check("abc_eop", got_q[i].eop, (i == 4) ? 1 : 0);
      end
      check("abc_window", got_q[4].data, 160'h6162636465);
    end

    // 25-byte packet: fill saturates at MAX_STR_SIZE
    got_q.delete();
    for (int i = 0; i < 25; i++) send_byte(8'(i + 1), i == 0, i == 24, 1'b0);
    drain(2);
    check("sat_beats", got_q.size(), 25);
    if (got_q.size() == 25) begin
      check("sat_mask19", got_q[18].mask, 20'h7FFFC);
      check("sat_mask20", got_q[19].mask, 20'hFFFFC);
      check("sat_mask25", got_q[24].mask, 20'hFFFFC);
      check("sat_window25", got_q[24].data, 160'h060708090a0b0c0d0e0f10111213141516171819);
      check("sat_eop25", got_q[24].eop, 1);
    end

    // Back-to-back "xyz" then "pq"
    got_q.delete();
    send_byte(8'h78, 1'b1, 1'b0, 1'b0);
    send_byte(8'h79, 1'b0, 1'b0, 1'b0);
    send_byte(8'h7a, 1'b0, 1'b1, 1'b0);
    send_byte(8'h70, 1'b1, 1'b0, 1'b0);
    send_byte(8'h71, 1'b0, 1'b1, 1'b0);
    drain(2);
    check("b2b_beats", got_q.size(), 5);
    if (got_q.size() == 5) begin
      check("b2b_z_mask", got_q[2].mask, 20'h4);
      check("b2b_p_window", got_q[3].data, 160'h70);
      check("b2b_p_mask", got_q[3].mask, 0);
      check("b2b_q_window", got_q[4].data, 160'h7071);
      check("b2b_q_mask", got_q[4].mask, 0);
    end

    // Backpressure for 3 cycles mid-packet
    got_q.delete();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i), i == 0, 1'b0, 1'b0);
    held_data = bus.src_data_o;
    held_mask = bus.src_len_mask_o;
    for (int s = 0; s < 3; s++) begin
      cycle(1'b1, 8'h35, 1'b0, 1'b0, 1'b0, a);
      check("stall_accept", a, 0);
      check("stall_snk_ready", bus.snk_ready_o, 0);
      check("stall_valid", bus.src_valid_o, 1);
      check("stall_data", bus.src_data_o, held_data);
      check("stall_mask", bus.src_len_mask_o, held_mask);
    end
    for (int i = 4; i < 8; i++) send_byte(8'(8'h31 + i), 1'b0, i == 7, 1'b0);
    drain(2);
    check("bp_beats", got_q.size(), 8);
    if (got_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("bp_mask", got_q[i].mask, bp_mask[i]);
        check("bp_byte", got_q[i].data[BYTE_W-1:0], 8'(8'h31 + i));
      end
    end

    // Asynchronous reset after 10 bytes of an open packet
    for (int i = 0; i < 10; i++) send_byte(8'(8'h51 + i), i == 0, 1'b0, 1'b0);
    check("pre_rst_valid", bus.src_valid_o, 1);
    bus.snk_valid_i = 1'b0;
    bus.src_ready_i = 1'b0;
    #3 rst_i = 1'b1;
    #1;
    check("async_rst_valid", bus.src_valid_o, 0);
    check("async_rst_snk_ready", bus.snk_ready_o, 1);
    check("async_rst_data", bus.src_data_o, 0);
    check("async_rst_mask", bus.src_len_mask_o, 0);
    hist.delete();
    m_in_pkt = 1'b0;
    exp_q.delete();
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    got_q.delete();
    send_byte(8'h41, 1'b0, 1'b0, 1'b0);
    send_byte(8'h42, 1'b0, 1'b1, 1'b0);
    drain(2);
    check("post_rst_beats", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("post_rst_window0", got_q[0].data, 160'h41);
      check("post_rst_mask0", got_q[0].mask, 0);
      check("post_rst_window1", got_q[1].data, 160'h4142);
      check("post_rst_mask1", got_q[1].mask, 0);
    end

    // Random valid/ready over 1000 bytes with packet lengths 1..40
    sent = 0;
    while (sent < 1000) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) send_byte(8'($urandom), i == 0, i == len - 1, 1'b1);
      sent += len;
    end
    drain(4);
    check("sb_leftover", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bloom_str_window.md
# bloom_str_window

Sliding-window front end of the bloom filter datapath. Accepts the byte stream to be searched on an Avalon-ST sink, maintains the last MAX_STR_SIZE bytes of the current packet, and emits one registered beat per input byte. Each output beat carries:
- the full byte window;
- a length mask marking which candidate substring lengths (MIN_STR_SIZE..MAX_STR_SIZE) ending at that byte lie wholly inside the packet.

It feeds the hash/LUT-lookup stage directly downstream.

## Interface
Parameters:
- BYTE_W, default 8: symbol width.
- MIN_STR_SIZE, default 3: shortest string length checked; 1 ≤ MIN_STR_SIZE ≤ MAX_STR_SIZE.
- MAX_STR_SIZE, default 20: window depth in bytes; ≥ 1.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset, asynchronous, active-high.
- snk_data_i  in  BYTE_W  input byte.
- snk_valid_i  in  1  input byte valid.
- snk_startofpacket_i  in  1  first byte of packet.
- snk_endofpacket_i  in  1  last byte of packet.
- snk_ready_o  out  1  byte accepted when snk_valid_i && snk_ready_o.
- src_data_o  out  MAX_STR_SIZE*BYTE_W  window; byte slot k (bits k*BYTE_W +: BYTE_W) = byte accepted k positions before the newest; slot 0 = newest.
- src_len_mask_o  out  MAX_STR_SIZE  bit k set ⇔ string of length k+1 ending at slot 0 is inside the current packet and k+1 ≥ MIN_STR_SIZE.
- src_endofpacket_o  out  1  beat corresponds to the packet's last byte.
- src_valid_o  out  1  output beat valid.
- src_ready_i  in  1  downstream ready.

## Operation
- State:
  - window register, MAX_STR_SIZE bytes;
  - fill counter, 0..MAX_STR_SIZE, width $clog2(MAX_STR_SIZE+1);
  - one-entry output register.
- Accept (snk_valid_i && snk_ready_o) updates the window:
  - shift toward higher slots by one; the oldest byte drops; snk_data_i enters slot 0.
  - If the byte starts a packet, all slots 1..MAX_STR_SIZE-1 load zero.
- A byte starts a packet when snk_startofpacket_i = 1, or it is the first byte after reset, or the previous accepted byte had endofpacket.
- Fill update on accept:
  - packet start → fill = 1;
  - otherwise fill = min(fill+1, MAX_STR_SIZE), saturating with no wrap.
- Mask from the updated fill: bit k = (k < fill) && (k+1 ≥ MIN_STR_SIZE).
  - Beats with fill < MIN_STR_SIZE are still forwarded, with an all-zero mask.
- Single-byte packet (sop and eop on the same beat): fill = 1, one beat out with eop = 1; the next byte starts fresh.
- No gating on sop/eop sequencing errors: eop without a prior sop is forwarded; a stray sop mid-packet restarts the window.

## Timing
- Reset values: src_valid_o = 0, src_data_o = 0, src_len_mask_o = 0, src_endofpacket_o = 0, fill = 0, window = 0.
  - snk_ready_o = 1 during and after reset (derived from src_valid_o = 0).
  - Reset mid-packet discards all state and any pending beat.
- Latency: a byte accepted at edge N appears on src_* after edge N, i.e. in cycle N+1.
- snk_ready_o = !src_valid_o || src_ready_i. This is combinational from src_ready_i and is the only comb path; there is no bubble.
- Output register:
  - loads on every accept;
  - clears src_valid_o when src_ready_i && !accept;
  - holds all src_* stable while src_valid_o && !src_ready_i.
- Simultaneous drain and accept in one cycle: the output register reloads and src_valid_o stays 1. Sustained throughput is 1 byte/cycle.
- The window and fill change only on accept; a stall freezes them.

## Structure
- BYTE_W, MIN_STR_SIZE, MAX_STR_SIZE come from bloom_filter_pkg as parameter defaults.
- Add to the package:
  - typedef str_window_t, a packed array [MAX_STR_SIZE-1:0] of logic [BYTE_W-1:0], shared with the hash stage;
  - localparam FILL_W = $clog2(MAX_STR_SIZE+1).
- Single module, no sub-modules; the output register is inline.

## Test plan
- Packet "abcde" (0x61..0x65), sop on a, eop on e, src_ready_i = 1 → 5 beats, one per cycle.
  - Masks: 0x00000, 0x00000, 0x00004, 0x0000C, 0x0001C.
  - Beat 5: slot 0 = 0x65, slot 4 = 0x61, slots 5..19 = 0; src_endofpacket_o = 1 on beat 5 only.
- 25-byte packet 0x01..0x19 → fill saturates at 20.
  - Beat 20 onward: mask = 0xFFFFC.
  - Beat 25: slot 0 = 0x19, slot 19 = 0x06.
- Back-to-back packets "xyz" then "pq" with no idle cycle → beat 4 (p): slots 1..19 = 0, mask 0.
  - Beat 5: mask 0, not 0x4.
- Backpressure: src_ready_i low for 3 cycles mid-packet → snk_ready_o low while src_valid_o = 1.
  - src_* are held stable, no byte is lost or duplicated, and the mask sequence matches the no-stall case.
- Reset asserted asynchronously mid-packet (after 10 bytes) → src_valid_o drops immediately.
  - The next byte without sop is treated as a packet start: mask 0, slots 1..19 = 0.
- Random valid/ready toggling over 1000 bytes with random packet lengths 1..40 → output matches a scoreboard model and no beat is lost or duplicated.
